eq_multiband_loader: RTL and testbench
======================================

// Module: eq_multiband_loader
// PURPOSE
//  Software-to-hardware handshake loader for a cascade of NBANDS biquad sections.
//  Receives the five coefficients for one selected band (b0,b1,b2,a1,a2) over a four-phase to_hw_sig/to_sw_sig handshake.
//  Double-buffers each word in a shadow set, then commits all five to that band's active registers atomically.
//  Also streams GRAPH_DEPTH response-graph bytes into graph RAM. Sits between the NIOS PIO and the filter cascade / VGA graph RAM.
// PARAMETERS
//  CW          18   coefficient width (signed)
//  NBANDS      4    number of biquad bands; band index width BAW = $clog2(NBANDS) (min 1)
//  GRAPH_DEPTH 517  graph RAM words per graph session
//  GAW         10   graph RAM address width (2**GAW >= GRAPH_DEPTH)
//  DW          8    graph RAM data width (DW <= CW)
// PORTS
//  Clk                in   1             system clock
//  Reset              in   1             reset, synchronous, active-high
//  to_hw_sig          in   4             SW command: 0 release, 1 strobe, 2 begin-coeff, 3 begin-graph, 15 abort
//  sw_data            in   CW            SW data word (band index on begin-coeff; coeff/graph byte on strobe)
//  coeffs_updated     in   1             filter cascade acknowledges the new coefficients
//  to_sw_sig          out  2             0 idle/released, 1 ack, 2 busy, 3 error
//  coeff_bus          out  NBANDS*5*CW   active coeffs; band n at [n*5*CW +: 5*CW], order {a2,a1,b2,b1,b0} MSB->LSB
//  load_coefficients  out  1             request to cascade to reload band load_band
//  load_band          out  BAW           band just committed
//  graph_we           out  1             graph RAM write enable
//  graph_waddr        out  GAW           graph RAM address
//  graph_wdata        out  DW            graph RAM data = sw_data[DW-1:0]
//  show_graph         out  1             sticky; set once the first graph session completes
//  state_out          out  4             current state encoding, for debug
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0; coeff_bus and shadow set 0; show_graph cleared; word/address counters 0.
//   Reset mid-session takes effect on the next edge and discards the session.
//  All outputs are registered or decoded from state only; nothing is combinational from to_hw_sig.
//  States: IDLE, CMD_ACK, WORD_WAIT, WORD_ACK, COMMIT, WAIT_UPD, GRAPH_WAIT, GRAPH_ACK, DONE, ERROR.
//  IDLE (to_sw_sig=0):
//   - to_hw_sig=2: if sw_data < NBANDS, latch band and go to CMD_ACK; otherwise go to ERROR.
//   - to_hw_sig=3: go to CMD_ACK in graph mode.
//   - Any other value is ignored.
//  CMD_ACK (to_sw_sig=1): on to_hw_sig=0, go to WORD_WAIT with k=0 (coeff mode) or GRAPH_WAIT with idx=0 (graph mode).
//  WORD_WAIT (to_sw_sig=0): on to_hw_sig=1, shadow[k] <= sw_data at that edge and go to WORD_ACK.
//  WORD_ACK (to_sw_sig=1): on to_hw_sig=0, go to COMMIT if k==4; otherwise k++ and go to WORD_WAIT.
//  COMMIT (1 cycle, to_sw_sig=2): active[band] <= shadow; other bands unchanged; load_coefficients=1; load_band=band.
//  WAIT_UPD (to_sw_sig=2): load_coefficients held 1 until coeffs_updated=1, then go to DONE.
//   coeffs_updated in any other state is ignored.
//  GRAPH_WAIT (to_sw_sig=0): on to_hw_sig=1, go to GRAPH_ACK.
//   The next cycle has graph_we=1 for exactly one cycle, with graph_waddr=idx and graph_wdata=sw_data[DW-1:0] captured at the strobe edge.
//  GRAPH_ACK (to_sw_sig=1): on to_hw_sig=0:
//   - if idx==GRAPH_DEPTH-1: set show_graph and go to DONE;
//   - otherwise idx++ and go to GRAPH_WAIT. No address wrap.
//  DONE (to_sw_sig=1): on to_hw_sig=0, go to IDLE.
//  ERROR (to_sw_sig=3): on to_hw_sig=0, go to IDLE. Nothing is modified.
//  Abort (to_hw_sig=15) in any state except IDLE: go to IDLE next cycle.
//   - Shadow is discarded, active coeffs stay unchanged, and load_coefficients drops.
//   - Graph words already written remain; show_graph is unchanged.
//   - Abort has priority over every other transition.
//  Holding to_hw_sig unchanged stalls indefinitely in any state; there is no timeout.
//  Strobe is level-sensitive: one capture per four-phase cycle. A strobe still high after capture never double-captures.
// TESTING
//  T1 Reset: assert Reset 2 cycles -> every output 0, state_out=IDLE.
//  T2 Load band 2 with 1,2,3,4,5:
//   -> to_sw_sig sequence 1,0,1,...;
//   -> COMMIT and WAIT_UPD hold load_coefficients=1, load_band=2, to_sw_sig=2;
//   -> coeffs_updated=1 -> DONE;
//   -> band 2 slice reads {5,4,3,2,1}; bands 0,1,3 remain 0.
//  T3 Band index 7 with NBANDS=4 -> to_sw_sig=3; release -> IDLE; coeff_bus unchanged.
//  T4 Graph session of 517 bytes, data=addr[7:0]:
//   -> 517 single-cycle graph_we pulses at addresses 0..516;
//   -> show_graph=1 after the last release.
//  T5 Abort after the 3rd coefficient of band 1 -> IDLE; band 1 keeps its old values; load_coefficients never asserts.
//  T6 Hold strobe 10 cycles in WORD_WAIT -> exactly one capture.
//   Reset asserted during WAIT_UPD -> coeff_bus=0 and load_coefficients=0 next cycle.

Source files
------------

// File: rtl/eq_multiband_loader.sv
// eq_multiband_loader: four-phase SW handshake loader for per-band biquad coefficients and response-graph RAM.
module eq_multiband_loader #(
   parameter int CW          = 18,
   parameter int NBANDS      = 4,
   parameter int GRAPH_DEPTH = 517,
   parameter int GAW         = 10,
   parameter int DW          = 8,
   parameter int BAW         = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [3:0]             to_hw_sig,
   input  logic [CW-1:0]          sw_data,
   input  logic                   coeffs_updated,
   output logic [1:0]             to_sw_sig,
   output logic [NBANDS*5*CW-1:0] coeff_bus,
   output logic                   load_coefficients,
   output logic [BAW-1:0]         load_band,
   output logic                   graph_we,
   output logic [GAW-1:0]         graph_waddr,
   output logic [DW-1:0]          graph_wdata,
   output logic                   show_graph,
   output logic [3:0]             state_out
);
   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      CMD_ACK    = 4'd1,
      WORD_WAIT  = 4'd2,
      WORD_ACK   = 4'd3,
      COMMIT     = 4'd4,
      WAIT_UPD   = 4'd5,
      GRAPH_WAIT = 4'd6,
      GRAPH_ACK  = 4'd7,
      DONE       = 4'd8,
      ERROR      = 4'd9
   } state_t;
   state_t          state;
   logic            graph_mode;
   logic [2:0]      k;
   logic [GAW-1:0]  idx;
   logic [BAW-1:0]  band;
   logic [5*CW-1:0] shadow;
   // Shadow words land LSB-first so b0 sits at the bottom of each band slice.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         graph_mode  <= 1'b0;
         k           <= '0;
         idx         <= '0;
         band        <= '0;
         shadow      <= '0;
         coeff_bus   <= '0;
         graph_we    <= 1'b0;
         graph_wdata <= '0;
         show_graph  <= 1'b0;
      end else begin
         graph_we <= 1'b0;
         if (state != IDLE && to_hw_sig == 4'd15)
            state <= IDLE;
         else
            case (state)
               IDLE:
                  if (to_hw_sig == 4'd2) begin
                     if (sw_data < CW'(NBANDS)) begin
                        band       <= sw_data[BAW-1:0];
                        graph_mode <= 1'b0;
                        state      <= CMD_ACK;
                     end else
                        state <= ERROR;
                  end else if (to_hw_sig == 4'd3) begin
                     graph_mode <= 1'b1;
                     state      <= CMD_ACK;
                  end
               CMD_ACK:
                  if (to_hw_sig == 4'd0) begin
                     k     <= '0;
                     idx   <= '0;
                     state <= graph_mode ? GRAPH_WAIT : WORD_WAIT;
                  end
               WORD_WAIT:
                  if (to_hw_sig == 4'd1) begin
                     shadow[k*CW +: CW] <= sw_data;
                     state              <= WORD_ACK;
                  end
               WORD_ACK:
                  if (to_hw_sig == 4'd0) begin
                     k     <= k + 3'd1;
                     state <= (k == 3'd4) ? COMMIT : WORD_WAIT;
                  end
               COMMIT: begin
                  coeff_bus[band*5*CW +: 5*CW] <= shadow;
                  state                        <= WAIT_UPD;
               end
               WAIT_UPD:
                  if (coeffs_updated) state <= DONE;
               GRAPH_WAIT:
                  if (to_hw_sig == 4'd1) begin
                     graph_we    <= 1'b1;
                     graph_wdata <= sw_data[DW-1:0];
                     state       <= GRAPH_ACK;
                  end
               GRAPH_ACK:
                  if (to_hw_sig == 4'd0) begin
                     if (idx == GAW'(GRAPH_DEPTH - 1)) begin
                        show_graph <= 1'b1;
                        state      <= DONE;
                     end else begin
                        idx   <= idx + 1'b1;
                        state <= GRAPH_WAIT;
                     end
                  end
               DONE, ERROR:
                  if (to_hw_sig == 4'd0) state <= IDLE;
               default: state <= IDLE;
            endcase
      end
   end
   always_comb begin
      to_sw_sig = (state == ERROR) ? 2'd3 :
                  (state == COMMIT || state == WAIT_UPD) ? 2'd2 :
                  (state == CMD_ACK || state == WORD_ACK || state == GRAPH_ACK || state == DONE) ? 2'd1 : 2'd0;
   end
   assign load_coefficients = (state == COMMIT) || (state == WAIT_UPD);
   assign load_band         = band;
   assign graph_waddr       = idx;
   assign state_out         = state;
endmodule

// File: tb/tb_eq_multiband_loader.sv
// tb_eq_multiband_loader: directed vectors for handshake, commit, graph streaming, abort and reset.
module tb_eq_multiband_loader;
   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [3:0]   to_hw_sig = '0;
   logic [17:0]  sw_data = '0;
   logic         coeffs_updated = 1'b0;
   logic [1:0]   to_sw_sig;
   logic [359:0] coeff_bus;
   logic         load_coefficients;
   logic [1:0]   load_band;
   logic         graph_we;
   logic [9:0]   graph_waddr;
   logic [7:0]   graph_wdata;
   logic         show_graph;
   logic [3:0]   state_out;
   int total = 0, bad = 0;
   int pulses = 0, graph_bad = 0;
   logic load_seen = 1'b0;
   logic [359:0] exp_bus = '0;
   typedef struct {
      logic [3:0]  cmd;
      logic [17:0] data;
      logic        cu;
      logic [1:0]  sw;
      logic [3:0]  st;
      logic        ld;
   } vec_t;
   vec_t vecs[16];
   eq_multiband_loader dut (
      .Clk(Clk), .Reset(Reset), .to_hw_sig(to_hw_sig), .sw_data(sw_data),
      .coeffs_updated(coeffs_updated), .to_sw_sig(to_sw_sig), .coeff_bus(coeff_bus),
      .load_coefficients(load_coefficients), .load_band(load_band), .graph_we(graph_we),
      .graph_waddr(graph_waddr), .graph_wdata(graph_wdata), .show_graph(show_graph),
      .state_out(state_out)
   );
   always #5 Clk = ~Clk;
   always @(negedge Clk) begin
      if (graph_we) begin
         if (graph_waddr != pulses[9:0] || graph_wdata != pulses[7:0]) graph_bad++;
         pulses++;
      end
      if (load_coefficients) load_seen = 1'b1;
   end
   task automatic tick;
      @(posedge Clk);
      #1;
   endtask
   task automatic hs(input logic [3:0] c, input logic [17:0] d);
      to_hw_sig = c;
      sw_data = d;
      tick();
   endtask
   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic load(input logic [17:0] b, input logic [89:0] w);
      hs(4'd2, b);
      hs(4'd0, 18'd0);
      for (int i = 0; i < 5; i++) begin
         hs(4'd1, w[i*18 +: 18]);
         hs(4'd0, 18'd0);
      end
      tick();
      coeffs_updated = 1'b1;
      tick();
      coeffs_updated = 1'b0;
      tick();
   endtask
   initial begin
      vecs[0]  = '{4'd2, 18'd2, 1'b0, 2'd1, 4'd1, 1'b0};
      vecs[1]  = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd2, 1'b0};
      vecs[2]  = '{4'd1, 18'd1, 1'b0, 2'd1, 4'd3, 1'b0};
      vecs[3]  = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd2, 1'b0};
      vecs[4]  = '{4'd1, 18'd2, 1'b0, 2'd1, 4'd3, 1'b0};
      vecs[5]  = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd2, 1'b0};
      vecs[6]  = '{4'd1, 18'd3, 1'b0, 2'd1, 4'd3, 1'b0};
      vecs[7]  = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd2, 1'b0};
      vecs[8]  = '{4'd1, 18'd4, 1'b0, 2'd1, 4'd3, 1'b0};
      vecs[9]  = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd2, 1'b0};
      vecs[10] = '{4'd1, 18'd5, 1'b0, 2'd1, 4'd3, 1'b0};
      vecs[11] = '{4'd0, 18'd0, 1'b0, 2'd2, 4'd4, 1'b1};
      vecs[12] = '{4'd0, 18'd0, 1'b0, 2'd2, 4'd5, 1'b1};
      vecs[13] = '{4'd0, 18'd0, 1'b0, 2'd2, 4'd5, 1'b1};
      vecs[14] = '{4'd0, 18'd0, 1'b1, 2'd1, 4'd8, 1'b0};
      vecs[15] = '{4'd0, 18'd0, 1'b0, 2'd0, 4'd0, 1'b0};
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_sw", to_sw_sig, 0);
      chk("rst_bus", coeff_bus, 0);
      chk("rst_load", load_coefficients, 0);
      chk("rst_band", load_band, 0);
      chk("rst_we", graph_we, 0);
      chk("rst_waddr", graph_waddr, 0);
      chk("rst_wdata", graph_wdata, 0);
      chk("rst_show", show_graph, 0);
      chk("rst_state", state_out, 0);
      coeffs_updated = 1'b1;
      hs(4'd15, 18'd0);
      coeffs_updated = 1'b0;
      chk("idle_ignore", state_out, 0);
      for (int i = 0; i < 16; i++) begin
         to_hw_sig = vecs[i].cmd;
         sw_data = vecs[i].data;
         coeffs_updated = vecs[i].cu;
         tick();
         chk($sformatf("t2_sw[%0d]", i), to_sw_sig, vecs[i].sw);
         chk($sformatf("t2_state[%0d]", i), state_out, vecs[i].st);
         chk($sformatf("t2_load[%0d]", i), load_coefficients, vecs[i].ld);
         if (vecs[i].ld) chk($sformatf("t2_band[%0d]", i), load_band, 2);
      end
      coeffs_updated = 1'b0;
      exp_bus[180 +: 90] = {18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
      chk("t2_bus", coeff_bus, exp_bus);
      hs(4'd2, 18'd7);
      chk("t3_err_sw", to_sw_sig, 3);
      chk("t3_err_state", state_out, 9);
      hs(4'd0, 18'd0);
      chk("t3_idle", state_out, 0);
      hs(4'd2, 18'd4);
      chk("t3_edge_err", to_sw_sig, 3);
      hs(4'd0, 18'd0);
      chk("t3_bus", coeff_bus, exp_bus);
      hs(4'd3, 18'd0);
      hs(4'd0, 18'd0);
      chk("t4_gwait", state_out, 6);
      for (int i = 0; i < 517; i++) begin
         hs(4'd1, 18'(i));
         if (i == 516) begin
            chk("t4_show_early", show_graph, 0);
            chk("t4_last_addr", graph_waddr, 516);
         end
         hs(4'd0, 18'd0);
      end
      chk("t4_done", state_out, 8);
      chk("t4_show", show_graph, 1);
      tick();
      chk("t4_idle", state_out, 0);
      chk("t4_pulses", 512'(pulses), 517);
      chk("t4_graph_bad", 512'(graph_bad), 0);
      load(18'd1, {18'h3FFFF, 18'h20000, 18'd300, 18'd200, 18'd100});
      exp_bus[90 +: 90] = {18'h3FFFF, 18'h20000, 18'd300, 18'd200, 18'd100};
      chk("t5_pre_bus", coeff_bus, exp_bus);
      load_seen = 1'b0;
      hs(4'd2, 18'd1);
      hs(4'd0, 18'd0);
      for (int i = 0; i < 3; i++) begin
         hs(4'd1, 18'(7 + i));
         hs(4'd0, 18'd0);
      end
      hs(4'd15, 18'd0);
      chk("t5_abort_state", state_out, 0);
      chk("t5_abort_sw", to_sw_sig, 0);
      hs(4'd0, 18'd0);
      chk("t5_bus", coeff_bus, exp_bus);
      chk("t5_no_load", load_seen, 0);
      chk("t5_show_kept", show_graph, 1);
      hs(4'd2, 18'd3);
      hs(4'd0, 18'd0);
      for (int i = 0; i < 10; i++) hs(4'd1, 18'(10 + i));
      chk("t6_hold_state", state_out, 3);
      hs(4'd0, 18'd0);
      chk("t6_next_wait", state_out, 2);
      for (int i = 0; i < 4; i++) begin
         hs(4'd1, 18'(20 + i));
         hs(4'd0, 18'd0);
      end
      chk("t6_commit", state_out, 4);
      tick();
      exp_bus[270 +: 90] = {18'd23, 18'd22, 18'd21, 18'd20, 18'd10};
      chk("t6_bus", coeff_bus, exp_bus);
      chk("t6_wait_upd", state_out, 5);
      chk("t6_load", load_coefficients, 1);
      chk("t6_band", load_band, 3);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("t6_rst_bus", coeff_bus, 0);
      chk("t6_rst_load", load_coefficients, 0);
      chk("t6_rst_state", state_out, 0);
      chk("t6_rst_show", show_graph, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
